// File: rtl/atoi_pkg.sv
// -----------------------------------------------------------------------------
// atoi_pkg
// Shared definitions for the decimal field parsers of the AVC reader:
//   - ASCII constants (digit range and the accepted field delimiters)
//   - error codes reported with each converted field
//   - sequencer state enum
//   - byte classification helpers
// -----------------------------------------------------------------------------
package atoi_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    localparam logic [7:0] DLM_SPACE = 8'h20;
    localparam logic [7:0] DLM_COMMA = 8'h2C;
    localparam logic [7:0] DLM_SEMI  = 8'h3B;
    localparam logic [7:0] DLM_CR    = 8'h0D;
    localparam logic [7:0] DLM_LF    = 8'h0A;
    localparam logic [7:0] DLM_TAB   = 8'h09;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_CHAR = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SKIP    = 2'd2,
        CONV    = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    function automatic logic is_delim(input logic [7:0] b);
        return (b == DLM_SPACE) || (b == DLM_COMMA) || (b == DLM_SEMI) ||
               (b == DLM_CR)    || (b == DLM_LF)    || (b == DLM_TAB);
    endfunction

endpackage

// File: rtl/atoi3_conv10.sv
// -----------------------------------------------------------------------------
// atoi3_conv10
// Combinational 3-digit ASCII-to-binary converter (0..999).
// Ports:
//   i_c0    in  8   hundreds digit (ASCII '0'..'9')
//   i_c1    in  8   tens digit
//   i_c2    in  8   units digit
//   o_value out 10  i_c0*100 + i_c1*10 + i_c2 (digit values)
// Inputs are assumed to be ASCII digits; the caller guarantees this.
// -----------------------------------------------------------------------------
module atoi3_conv10
    import atoi_pkg::*;
(
    input  logic [7:0] i_c0,
    input  logic [7:0] i_c1,
    input  logic [7:0] i_c2,
    output logic [9:0] o_value
);

    logic [9:0] w_d0;
    logic [9:0] w_d1;
    logic [9:0] w_d2;

    assign w_d0 = {2'b00, i_c0} - {2'b00, ASCII_ZERO};
    assign w_d1 = {2'b00, i_c1} - {2'b00, ASCII_ZERO};
    assign w_d2 = {2'b00, i_c2} - {2'b00, ASCII_ZERO};

    // x100 = x64 + x32 + x4, x10 = x8 + x2; 999 fits in 10 bits.
    assign o_value = (w_d0 << 6) + (w_d0 << 5) + (w_d0 << 2)
                   + (w_d1 << 3) + (w_d1 << 1)
                   + w_d2;

endmodule

// File: rtl/atoi_field_seq.sv
// -----------------------------------------------------------------------------
// atoi_field_seq
// Collects 1..MAX_DIGITS ASCII digits terminated by a delimiter, right-aligns
// them into a 3-char window padded with '0', converts the window and emits one
// 8-bit value per field with a one-cycle valid strobe and an error code.
// Ports:
//   clk        in  1  clock, rising edge
//   reset      in  1  asynchronous active-high reset
//   flush      in  1  synchronous abort of the field in progress (no output)
//   in_valid   in  1  in_data holds a byte
//   in_data    in  8  ASCII byte
//   in_ready   out 1  byte accepted this cycle when in_valid is high
//   num        out 8  converted value, held until the next num_valid
//   num_valid  out 1  one-cycle pulse: num/num_err are new
//   num_err    out 2  00 ok, 01 illegal char, 10 too many digits, 11 overflow
//   field_cnt  out 8  number of emitted fields (wraps)
// -----------------------------------------------------------------------------
module atoi_field_seq
    import atoi_pkg::*;
#(
    parameter int SAT_ON_OVF = 1,
    parameter int MAX_DIGITS = 3
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] num,
    output logic       num_valid,
    output logic [1:0] num_err,
    output logic [7:0] field_cnt
);

    localparam logic [1:0] MAXD = 2'(MAX_DIGITS);

    state_t     r_state, w_nxt_state;
    logic [7:0] r_c0, r_c1, r_c2;
    logic [7:0] w_nxt_c0, w_nxt_c1, w_nxt_c2;
    logic [1:0] r_cnt, w_nxt_cnt;
    logic [1:0] r_err, w_nxt_err;

    logic [7:0] r_num;
    logic       r_num_valid;
    logic [1:0] r_num_err;
    logic [7:0] r_field_cnt;

    logic       w_take;
    logic       w_is_digit;
    logic       w_is_delim;
    logic       w_fire;
    logic [9:0] w_value;
    logic [7:0] w_num;
    logic [1:0] w_num_err;

    function automatic logic [7:0] sat_u8(input logic [9:0] v);
        if ((SAT_ON_OVF != 0) && (v > 10'd255))
            return 8'hFF;
        return v[7:0];
    endfunction

    atoi3_conv10 u_conv (
        .i_c0    (r_c0),
        .i_c1    (r_c1),
        .i_c2    (r_c2),
        .o_value (w_value)
    );

    assign in_ready   = (r_state != CONV);
    assign w_take     = in_valid && in_ready;
    assign w_is_digit = is_digit(in_data);
    assign w_is_delim = is_delim(in_data);
    // flush in the CONV cycle suppresses the output.
    assign w_fire     = (r_state == CONV) && !flush;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_c0    = r_c0;
        w_nxt_c1    = r_c1;
        w_nxt_c2    = r_c2;
        w_nxt_cnt   = r_cnt;
        w_nxt_err   = r_err;

        if (flush || (r_state == CONV)) begin
            w_nxt_state = IDLE;
            w_nxt_c0    = ASCII_ZERO;
            w_nxt_c1    = ASCII_ZERO;
            w_nxt_c2    = ASCII_ZERO;
            w_nxt_cnt   = 2'd0;
            w_nxt_err   = ERR_OK;
        end else if (w_take) begin
            unique case (r_state)
                IDLE, COLLECT: begin
                    if (w_is_digit) begin
                        if (r_state == IDLE || r_cnt < MAXD) begin
                            w_nxt_c0    = r_c1;
                            w_nxt_c1    = r_c2;
                            w_nxt_c2    = in_data;
                            w_nxt_cnt   = r_cnt + 2'd1;
                            w_nxt_state = COLLECT;
                        end else begin
                            w_nxt_err   = ERR_LEN;
                            w_nxt_state = SKIP;
                        end
                    end else if (w_is_delim) begin
                        // A delimiter with no field in progress is ignored.
                        if (r_state == COLLECT)
                            w_nxt_state = CONV;
                    end else begin
                        w_nxt_err   = ERR_CHAR;
                        w_nxt_state = SKIP;
                    end
                end
                SKIP: begin
                    // The first error stays latched; only a delimiter ends the field.
                    if (w_is_delim)
                        w_nxt_state = CONV;
                end
                default: w_nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_num     = w_value[7:0];
        w_num_err = ERR_OK;
        if (r_err != ERR_OK) begin
            w_num     = 8'd0;
            w_num_err = r_err;
        end else if (w_value > 10'd255) begin
            w_num     = sat_u8(w_value);
            w_num_err = ERR_OVF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_c0        <= ASCII_ZERO;
            r_c1        <= ASCII_ZERO;
            r_c2        <= ASCII_ZERO;
            r_cnt       <= 2'd0;
            r_err       <= ERR_OK;
            r_num       <= 8'd0;
            r_num_valid <= 1'b0;
            r_num_err   <= ERR_OK;
            r_field_cnt <= 8'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_c0        <= w_nxt_c0;
            r_c1        <= w_nxt_c1;
            r_c2        <= w_nxt_c2;
            r_cnt       <= w_nxt_cnt;
            r_err       <= w_nxt_err;
            r_num_valid <= w_fire;
            if (w_fire) begin
                r_num       <= w_num;
                r_num_err   <= w_num_err;
                r_field_cnt <= r_field_cnt + 8'd1;
            end
        end
    end

    assign num       = r_num;
    assign num_valid = r_num_valid;
    assign num_err   = r_num_err;
    assign field_cnt = r_field_cnt;

endmodule

// File: tb/tb_atoi_field_seq.sv
module tb_atoi_field_seq;

    localparam int MAX_DIGITS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready,  in_ready0;
    logic [7:0] num,       num0;
    logic       num_valid, num_valid0;
    logic [1:0] num_err,   num_err0;
    logic [7:0] field_cnt, field_cnt0;

    always #5 clk = ~clk;

    atoi_field_seq #(.SAT_ON_OVF(1), .MAX_DIGITS(MAX_DIGITS)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .num(num), .num_valid(num_valid), .num_err(num_err),
        .field_cnt(field_cnt)
    );

    atoi_field_seq #(.SAT_ON_OVF(0), .MAX_DIGITS(MAX_DIGITS)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .num(num0), .num_valid(num_valid0), .num_err(num_err0),
        .field_cnt(field_cnt0)
    );

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int pulses = 0;
    logic [7:0] last1 = 8'd0;
    logic [7:0] last0 = 8'd0;
    logic [1:0] laste = 2'b00;

    // Reference model: the field seen so far as a list of digits plus the first error.
    logic [7:0] m_digits[$];
    bit         m_in_field;
    logic [1:0] m_err;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit tb_digit(input logic [7:0] b);
        return b >= 8'h30 && b <= 8'h39;
    endfunction

    function automatic bit tb_delim(input logic [7:0] b);
        return b == 8'h20 || b == 8'h2C || b == 8'h3B || b == 8'h0D || b == 8'h0A || b == 8'h09;
    endfunction

    task automatic model_clear();
        m_digits.delete();
        m_in_field = 0;
        m_err = 2'b00;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit prod,
                              output logic [7:0] n1, output logic [7:0] n0, output logic [1:0] e);
        int v;
        prod = 0; n1 = 0; n0 = 0; e = 0;
        if (tb_digit(b)) begin
            m_in_field = 1;
            if (m_err == 2'b00) begin
                if (m_digits.size() == MAX_DIGITS) m_err = 2'b10;
                else m_digits.push_back(b);
            end
        end else if (tb_delim(b)) begin
            if (m_in_field) begin
                prod = 1;
                if (m_err != 2'b00) begin
                    e = m_err;
                end else begin
                    v = 0;
                    foreach (m_digits[i]) v = v * 10 + int'(m_digits[i]) - 48;
                    if (v > 255) begin
                        e = 2'b11; n1 = 8'd255; n0 = 8'(v % 256);
                    end else begin
                        n1 = 8'(v); n0 = 8'(v);
                    end
                end
                model_clear();
            end
        end else begin
            m_in_field = 1;
            if (m_err == 2'b00) m_err = 2'b01;
        end
    endtask

    // Offer one byte with valid/ready; kill=1 asserts flush in the CONV cycle.
    task automatic send(input logic [7:0] b, input bit kill);
        bit rdy;
        int guard;
        bit prod;
        logic [7:0] e1, e0;
        logic [1:0] ee;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        rdy = in_ready;
        while (!rdy && guard < 4) begin
            @(negedge clk);
            rdy = in_ready;
            guard++;
        end
        if (!rdy) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_byte(b, prod, e1, e0, ee);
        check("nv_after_accept", num_valid, 0);
        check("num_held", num, last1);
        check("err_held", num_err, laste);
        if (prod) begin
            check("rdy_in_conv", in_ready, 0);
            if (kill) begin
                @(negedge clk);
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                check("flush_conv_nv", num_valid, 0);
                check("flush_conv_cnt", field_cnt, exp_cnt % 256);
            end else begin
                @(posedge clk);
                #1;
                exp_cnt++;
                last1 = e1; last0 = e0; laste = ee;
                if (num_valid) pulses++;
                check("nv_pulse", num_valid, 1);
                check("nv_pulse_sat0", num_valid0, 1);
                check("num", num, e1);
                check("num_sat0", num0, e0);
                check("num_err", num_err, ee);
                check("num_err_sat0", num_err0, ee);
                check("field_cnt", field_cnt, exp_cnt % 256);
                check("rdy_after_conv", in_ready, 1);
            end
        end else begin
            check("field_cnt_hold", field_cnt0, exp_cnt % 256);
        end
    endtask

    task automatic do_flush(input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = with_byte;
        in_data  = b;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        check("flush_nv", num_valid, 0);
        check("flush_cnt", field_cnt, exp_cnt % 256);
    endtask

    task automatic send_str(input logic [63:0] s, input int len);
        logic [63:0] t;
        t = s;
        for (int j = 0; j < len; j++) send(t[8*(len-1-j) +: 8], 1'b0);
    endtask

    typedef struct {
        logic [63:0] s;
        int          len;
        int          nout;
        logic [7:0]  n1;
        logic [7:0]  n0;
        logic [1:0]  e;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r;
        logic [7:0] b;
        logic [7:0] dl[6];

        tbl[0]  = '{"7 ",       2, 1, 8'd7,   8'd7,   2'b00};
        tbl[1]  = '{"255,",     4, 1, 8'd255, 8'd255, 2'b00};
        tbl[2]  = '{"042\n",    4, 1, 8'd42,  8'd42,  2'b00};
        tbl[3]  = '{"300;",     4, 1, 8'd255, 8'd44,  2'b11};
        tbl[4]  = '{"1234 ",    5, 1, 8'd0,   8'd0,   2'b10};
        tbl[5]  = '{"1A5 ",     4, 1, 8'd0,   8'd0,   2'b01};
        tbl[6]  = '{"  ,,",     4, 0, 8'd0,   8'd0,   2'b00};
        tbl[7]  = '{"999\t",    4, 1, 8'd255, 8'd231, 2'b11};
        tbl[8]  = '{"256\015",  4, 1, 8'd255, 8'd0,   2'b11};
        tbl[9]  = '{"0 ",       2, 1, 8'd0,   8'd0,   2'b00};
        tbl[10] = '{"A12345,",  7, 1, 8'd0,   8'd0,   2'b01};
        tbl[11] = '{"1234A ",   6, 1, 8'd0,   8'd0,   2'b10};
        tbl[12] = '{"007 ",     4, 1, 8'd7,   8'd7,   2'b00};
        tbl[13] = '{"19;",      3, 1, 8'd19,  8'd19,  2'b00};

        dl[0] = 8'h20; dl[1] = 8'h2C; dl[2] = 8'h3B;
        dl[3] = 8'h0D; dl[4] = 8'h0A; dl[5] = 8'h09;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_num", num, 0);
        check("rst_nv", num_valid, 0);
        check("rst_err", num_err, 0);
        check("rst_cnt", field_cnt, 0);
        check("rst_rdy", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors
        for (int i = 0; i < 14; i++) begin
            p0 = pulses;
            send_str(tbl[i].s, tbl[i].len);
            check($sformatf("tbl%0d_pulses", i), pulses - p0, tbl[i].nout);
            if (tbl[i].nout > 0) begin
                check($sformatf("tbl%0d_num", i), num, tbl[i].n1);
                check($sformatf("tbl%0d_num_sat0", i), num0, tbl[i].n0);
                check($sformatf("tbl%0d_err", i), num_err, tbl[i].e);
            end
        end

        // "12", flush, "9 " -> one output of 9
        p0 = pulses;
        send("1", 0); send("2", 0);
        do_flush(1'b0, 8'h00);
        send("9", 0); send(" ", 0);
        check("flush_seq_pulses", pulses - p0, 1);
        check("flush_seq_num", num, 9);
        check("flush_seq_err", num_err, 0);

        // A byte offered together with flush is dropped
        do_flush(1'b1, "5");
        p0 = pulses;
        send(" ", 0);
        check("flush_drop_pulses", pulses - p0, 0);

        // flush in the CONV cycle suppresses the output
        p0 = pulses;
        send("5", 0); send(",", 1);
        check("flush_conv_pulses", pulses - p0, 0);
        check("flush_conv_num", num, 9);

        // Asynchronous reset in the middle of "25"
        send("8", 0); send(" ", 0);
        send("2", 0); send("5", 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_num", num, 0);
        check("arst_err", num_err, 0);
        check("arst_cnt", field_cnt, 0);
        check("arst_nv", num_valid, 0);
        check("arst_rdy", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        exp_cnt = 0; last1 = 0; last0 = 0; laste = 0;
        send("3", 0); send(8'h0A, 0);
        check("post_rst_num", num, 3);
        check("post_rst_cnt", field_cnt, 1);

        // field_cnt wraps after 256 fields
        for (int k = 0; k < 255; k++) begin
            send("1", 0); send(" ", 0);
        end
        check("cnt_wrap", field_cnt, 0);

        // Randomized stream against the model
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_flush(1'($urandom_range(0, 1)), 8'h30 + 8'($urandom_range(0, 9)));
            end else begin
                r = $urandom_range(0, 99);
                if (r < 55) b = 8'h30 + 8'($urandom_range(0, 9));
                else if (r < 80) b = dl[$urandom_range(0, 5)];
                else begin
                    b = 8'($urandom_range(0, 255));
                    while (tb_digit(b) || tb_delim(b)) b = 8'($urandom_range(0, 255));
                end
                send(b, $urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
